// File: rtl/clk_div_bank.sv
// clk_div_bank
//   Bank of N_CH glitch-free 50%-duty clock dividers running off CLK. Each
//   channel has a runtime-programmable half-period (shadow register, applied
//   only at the LOW->HIGH boundary so no runt pulse is ever produced), a
//   registered divided clock and a one-cycle tick on each rising edge.
//   Channel 0 also drives a lock indicator.
//
// Ports
//   CLK       in   source clock, all logic on posedge
//   reset     in   synchronous, active-high reset
//   en        in   global run enable
//   div_val   in   [N_CH*DIV_W] half-period per channel, slice i*DIV_W +: DIV_W
//   div_load  in   [N_CH] per-channel strobe, captures slice into shadow
//   clk_out   out  [N_CH] divided clocks (registered)
//   tick      out  [N_CH] one-CLK pulse with each clk_out rising edge
//   locked    out  channel 0 has run LOCK_PERIODS periods on one divisor
//   clk_pass  out  en ? CLK : 0 (combinational gate)
//
// Channel FSM
//   state | meaning
//   IDLE  | output low, waiting for en and a non-zero half-period
//   HIGH  | output high, cnt runs 1..half
//   LOW   | output low, cnt runs 1..half; end of LOW is the only point where
//         | a new divisor is applied or the channel stops
module clk_div_bank #(
  parameter int N_CH         = 2,
  parameter int DIV_W        = 8,
  parameter int LOCK_PERIODS = 4
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   en,
  input  logic [N_CH*DIV_W-1:0]  div_val,
  input  logic [N_CH-1:0]        div_load,
  output logic [N_CH-1:0]        clk_out,
  output logic [N_CH-1:0]        tick,
  output logic                   locked,
  output logic                   clk_pass
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_TH = 4'(LOCK_PERIODS);

  assign clk_pass = en & CLK;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t             state;
    logic [DIV_W-1:0]   cnt;
    logic [DIV_W-1:0]   half;
    logic [DIV_W-1:0]   shadow;
    logic [DIV_W-1:0]   eff_half;
    logic               pending;
    logic               boundary;
    logic               go;
    logic               apply;
    logic               clk_q;
    logic               tick_q;

    // eff_half is the half-period the next period would use if it started now.
    always_comb begin
      eff_half = pending ? shadow : half;
      boundary = (state == IDLE) || ((state == LOW) && (cnt == half));
      go       = en && boundary && (eff_half != '0);
      apply    = en && boundary && pending;
    end

    always_ff @(posedge CLK) begin
      if (reset) begin
        state   <= IDLE;
        cnt     <= '0;
        half    <= '0;
        shadow  <= '0;
        pending <= 1'b0;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        tick_q <= 1'b0;

        // A load on the same edge as an apply wins the pending flag, so the
        // freshly written value is held for the following boundary.
        if (div_load[i]) begin
          shadow  <= div_val[i*DIV_W +: DIV_W];
          pending <= 1'b1;
        end else if (apply) begin
          pending <= 1'b0;
        end

        if (apply) half <= shadow;

        if (go) begin
          state  <= HIGH;
          clk_q  <= 1'b1;
          cnt    <= DIV_W'(1);
          tick_q <= 1'b1;
        end else begin
          case (state)
            HIGH: begin
              if (cnt == half) begin
                state <= LOW;
                clk_q <= 1'b0;
                cnt   <= DIV_W'(1);
              end else begin
                cnt <= cnt + DIV_W'(1);
              end
            end
            LOW: begin
              if (cnt == half) begin
                state <= IDLE;
                clk_q <= 1'b0;
                cnt   <= '0;
              end else begin
                cnt <= cnt + DIV_W'(1);
              end
            end
            default: begin
              state <= IDLE;
              clk_q <= 1'b0;
              cnt   <= '0;
            end
          endcase
        end
      end
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;

    if (i == 0) begin : g_lock
      logic [3:0] lock_cnt;
      logic [3:0] lock_nxt;
      logic       new_div;
      logic       stop;

      // Channel 0 leaving LOW without starting a new period means it idles.
      assign stop = (state == LOW) && (cnt == half) && !go;

      // new_div is aligned with tick_q: it marks a period that began with a
      // freshly applied divisor, which restarts the lock count.
      always_comb begin
        lock_nxt = lock_cnt;
        if (stop) begin
          lock_nxt = '0;
        end else if (tick_q) begin
          if (new_div)
            lock_nxt = 4'd1;
          else if (lock_cnt != 4'hF)
            lock_nxt = lock_cnt + 4'd1;
        end
      end

      always_ff @(posedge CLK) begin
        if (reset) begin
          lock_cnt <= '0;
          locked   <= 1'b0;
          new_div  <= 1'b0;
        end else begin
          lock_cnt <= lock_nxt;
          locked   <= (lock_nxt >= LOCK_TH);
          new_div  <= go && apply;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank
//   Directed bench for clk_div_bank (N_CH=2, DIV_W=8, LOCK_PERIODS=4).
//   A vector table covers reset, first load and the run up to lock; short
//   hand-written sequences cover divisor changes, enable drop/reassert,
//   zero load, double load, reset mid-period and the maximum half-period.
module tb_clk_div_bank;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [15:0] div_val = '0;
  logic [1:0]  div_load = '0;
  logic [1:0]  clk_out;
  logic [1:0]  tick;
  logic        locked;
  logic        clk_pass;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  clk_div_bank #(.N_CH(2), .DIV_W(8), .LOCK_PERIODS(4)) dut (
    .CLK      (CLK),
    .reset    (reset),
    .en       (en),
    .div_val  (div_val),
    .div_load (div_load),
    .clk_out  (clk_out),
    .tick     (tick),
    .locked   (locked),
    .clk_pass (clk_pass)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic [1:0]  load;
    logic [15:0] dval;
    logic [1:0]  clk;
    logic [1:0]  tk;
    logic        lk;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(input logic rst, input logic e, input logic [1:0] ld,
                             input logic [15:0] dv, input logic [1:0] c,
                             input logic [1:0] t, input logic l);
    vec_t r;
    r.rst = rst; r.en = e; r.load = ld; r.dval = dv;
    r.clk = c; r.tk = t; r.lk = l;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_tick(input int ch, input int limit, output int n);
    n = 0;
    while (tick[ch] !== 1'b1 && n < limit) begin
      step();
      n++;
    end
  endtask

  // Counts consecutive samples (current one included) where clk_out[ch]==val.
  task automatic measure(input int ch, input logic val, input int limit, output int n);
    n = 0;
    while (clk_out[ch] === val && n < limit) begin
      n++;
      step();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int t0;
    int t1;
    int bad;

    // rst en load  dval      clk    tick   lk
    vq.push_back(v(1, 0, 2'b00, 16'h0000, 2'b00, 2'b00, 0));
    vq.push_back(v(1, 0, 2'b00, 16'h0000, 2'b00, 2'b00, 0));
    vq.push_back(v(0, 0, 2'b11, 16'h0103, 2'b00, 2'b00, 0));
    vq.push_back(v(0, 0, 2'b00, 16'h0000, 2'b00, 2'b00, 0));
    vq.push_back(v(0, 1, 2'b00, 16'h0000, 2'b11, 2'b11, 0)); // k=0 first tick
    vq.push_back(v(0, 1, 2'b00, 16'h0000, 2'b01, 2'b00, 0));
    vq.push_back(v(0, 1, 2'b00, 16'h0000, 2'b11, 2'b10, 0));
    vq.push_back(v(0, 1, 2'b00, 16'h0000, 2'b00, 2'b00, 0));
    vq.push_back(v(0, 1, 2'b00, 16'h0000, 2'b10, 2'b10, 0));
    vq.push_back(v(0, 1, 2'b00, 16'h0000, 2'b00, 2'b00, 0));
    vq.push_back(v(0, 1, 2'b00, 16'h0000, 2'b11, 2'b11, 0)); // k=6 2nd tick0
    vq.push_back(v(0, 1, 2'b00, 16'h0000, 2'b01, 2'b00, 0));
    vq.push_back(v(0, 1, 2'b00, 16'h0000, 2'b11, 2'b10, 0));
    vq.push_back(v(0, 1, 2'b00, 16'h0000, 2'b00, 2'b00, 0));
    vq.push_back(v(0, 1, 2'b00, 16'h0000, 2'b10, 2'b10, 0));
    vq.push_back(v(0, 1, 2'b00, 16'h0000, 2'b00, 2'b00, 0));
    vq.push_back(v(0, 1, 2'b00, 16'h0000, 2'b11, 2'b11, 0)); // k=12 3rd tick0
    vq.push_back(v(0, 1, 2'b00, 16'h0000, 2'b01, 2'b00, 0));
    vq.push_back(v(0, 1, 2'b00, 16'h0000, 2'b11, 2'b10, 0));
    vq.push_back(v(0, 1, 2'b00, 16'h0000, 2'b00, 2'b00, 0));
    vq.push_back(v(0, 1, 2'b00, 16'h0000, 2'b10, 2'b10, 0));
    vq.push_back(v(0, 1, 2'b00, 16'h0000, 2'b00, 2'b00, 0));
    vq.push_back(v(0, 1, 2'b00, 16'h0000, 2'b11, 2'b11, 0)); // k=18 4th tick0
    vq.push_back(v(0, 1, 2'b00, 16'h0000, 2'b01, 2'b00, 1)); // locked next cycle
    vq.push_back(v(0, 1, 2'b00, 16'h0000, 2'b11, 2'b10, 1));

    foreach (vq[i]) begin
      reset    = vq[i].rst;
      en       = vq[i].en;
      div_load = vq[i].load;
      div_val  = vq[i].dval;
      step();
      chk($sformatf("vec%0d_clk_out", i), 32'(clk_out), 32'(vq[i].clk));
      chk($sformatf("vec%0d_tick", i), 32'(tick), 32'(vq[i].tk));
      chk($sformatf("vec%0d_locked", i), 32'(locked), 32'(vq[i].lk));
      chk($sformatf("vec%0d_clk_pass", i), 32'(clk_pass), 32'(vq[i].en));
    end

    // Divisor change 3 -> 5 loaded mid-HIGH of channel 0.
    wait_tick(0, 20, n);
    chk("t2_sync", 32'(tick[0]), 1);
    div_val = 16'h0005; div_load = 2'b01; step(); div_load = 2'b00;
    wait_tick(0, 40, n);
    chk("t2_old_period", n + 1, 6);
    measure(0, 1'b1, 40, n);
    chk("t2_new_high", n, 5);
    chk("t2_lock_drop", 32'(locked), 0);
    measure(0, 1'b0, 40, n);
    chk("t2_new_low", n, 5);
    chk("t2_tick", 32'(tick[0]), 1);
    n = 0;
    while (!locked && n < 80) begin
      step();
      n++;
    end
    chk("t2_relock_cycles", n, 21);

    // en dropped one cycle into HIGH with half=4.
    div_val = 16'h0004; div_load = 2'b01; step(); div_load = 2'b00;
    wait_tick(0, 40, n);
    chk("t3_sync", 32'(tick[0]), 1);
    chk("t3_pass_on", 32'(clk_pass), 1);
    en = 1'b0;
    #1;
    chk("t3_pass_off", 32'(clk_pass), 0);
    measure(0, 1'b1, 20, n);
    chk("t3_high", n, 4);
    measure(0, 1'b0, 30, n);
    chk("t3_hold_low", n, 30);
    chk("t3_locked", 32'(locked), 0);
    chk("t3_idle_out", 32'({tick, clk_out}), 0);
    en = 1'b1; step();
    chk("t3_restart_tick", 32'(tick), 3);
    chk("t3_restart_clk", 32'(clk_out), 3);
    en = 1'b0; step(); en = 1'b1;
    measure(0, 1'b1, 20, n);
    chk("t3_resume_high", n, 3);
    measure(0, 1'b0, 20, n);
    chk("t3_resume_low", n, 4);
    chk("t3_no_gap", 32'(tick[0]), 1);

    // Zero load on running channel 0; channel 1 keeps running.
    div_val = 16'h0000; div_load = 2'b01; step(); div_load = 2'b00;
    measure(0, 1'b1, 20, n);
    chk("t4_finish_high", n, 3);
    measure(0, 1'b0, 20, n);
    chk("t4_hold_low", n, 20);
    t0 = 0; t1 = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      t0 += int'(tick[0]);
      t1 += int'(tick[1]);
    end
    chk("t4_no_tick0", t0, 0);
    chk("t4_ch1_ticks", t1, 10);

    // Two loads on channel 1 within one period: last one wins.
    wait_tick(1, 10, n);
    chk("t6_sync", 32'(tick[1]), 1);
    div_val = 16'h0300; div_load = 2'b10; step(); div_load = 2'b00;
    wait_tick(1, 10, n);
    chk("t6_apply3", 32'(tick[1]), 1);
    div_val = 16'h0200; div_load = 2'b10; step();
    div_val = 16'h0700; step(); div_load = 2'b00;
    wait_tick(1, 20, n);
    chk("t6_period_kept", n + 2, 6);
    measure(1, 1'b1, 20, n);
    chk("t6_high7", n, 7);
    measure(1, 1'b0, 20, n);
    chk("t6_low7", n, 7);
    chk("t6_tick", 32'(tick[1]), 1);

    // Reset mid-HIGH on both channels.
    div_val = 16'h0002; div_load = 2'b01; step(); div_load = 2'b00;
    step();
    chk("t5_ch0_start", 32'(tick[0]), 1);
    reset = 1'b1; step();
    chk("t5_rst_clk", 32'(clk_out), 0);
    chk("t5_rst_tick", 32'(tick), 0);
    chk("t5_rst_locked", 32'(locked), 0);
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (clk_out != 2'b00 || tick != 2'b00) bad++;
    end
    chk("t5_idle_after_rst", bad, 0);
    div_val = 16'h0002; div_load = 2'b01; step(); div_load = 2'b00;
    wait_tick(0, 5, n);
    chk("t5_reload_tick", 32'(tick[0]), 1);
    measure(0, 1'b1, 20, n);
    chk("t5_high2", n, 2);
    measure(0, 1'b0, 20, n);
    chk("t5_low2", n, 2);

    // Maximum half-period on channel 1.
    div_val = 16'hFF00; div_load = 2'b10; step(); div_load = 2'b00;
    wait_tick(1, 5, n);
    chk("tmax_start", 32'(tick[1]), 1);
    measure(1, 1'b1, 300, n);
    chk("tmax_high", n, 255);
    measure(1, 1'b0, 300, n);
    chk("tmax_low", n, 255);
    chk("tmax_tick", 32'(tick[1]), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
